// File: rtl/uart_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_arb_pkg
// Brief    : Shared types and round-robin pick helper for uart_tx_arbiter.
// Revision : 1.0
// ============================================================================
package uart_arb_pkg;

    localparam int unsigned MAX_REQ = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_e;

    // First set bit of req scanning upward from last+1, wrapping modulo num.
    // Returns last when nothing is requesting.
    function automatic logic [2:0] rr_pick(
        input logic [MAX_REQ-1:0] req,
        input logic [2:0]         last,
        input int unsigned        num
    );
        logic [2:0] pick;
        logic [2:0] idx;
        logic       found;
        pick  = last;
        found = 1'b0;
        for (int unsigned k = 1; k <= MAX_REQ; k++) begin
            if (k <= num) begin
                idx = 3'((32'(last) + k) % num);
                if (!found && req[idx]) begin
                    pick  = idx;
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage : uart_arb_pkg
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : rr_picker
// Brief    : Combinational round-robin priority encoder over NUM_REQ requests.
// Revision : 1.0
// ============================================================================
module rr_picker
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [$clog2(NUM_REQ)-1:0] i_last,
    output logic [$clog2(NUM_REQ)-1:0] o_pick,
    output logic                       o_any
);

    localparam int c_idx_w = $clog2(NUM_REQ);

    logic [MAX_REQ-1:0] w_req_ext;
    logic [2:0]         w_last_ext;

    assign w_req_ext  = 8'(i_req);
    assign w_last_ext = 3'(i_last);
    assign o_pick     = c_idx_w'(rr_pick(w_req_ext, w_last_ext, NUM_REQ));
    assign o_any      = |i_req;

endmodule : rr_picker
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Packet-granular round-robin arbiter sharing one UART TX byte port.
// Revision : 1.0
// ============================================================================
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ       = 3,
    parameter int MAX_PKT_LEN   = 64,
    parameter int STALL_TIMEOUT = 255
) (
    input  logic                       osc_clk,
    input  logic                       osc_reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx_valid,
    output logic [7:0]                 tx_data,
    input  logic                       tx_ready,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       forced_release
);

    localparam int c_idx_w   = $clog2(NUM_REQ);
    localparam int c_cnt_w   = $clog2(MAX_PKT_LEN + 1);
    localparam int c_stall_w = $clog2(STALL_TIMEOUT + 1);

    localparam logic [0:0] c_st_idle = IDLE;
    localparam logic [0:0] c_st_xfer = XFER;

    localparam logic [c_cnt_w-1:0]   c_cnt_max   = c_cnt_w'(MAX_PKT_LEN);
    localparam logic [c_stall_w-1:0] c_stall_max = c_stall_w'(STALL_TIMEOUT);
    localparam logic [c_idx_w-1:0]   c_last_rst  = c_idx_w'(NUM_REQ - 1);

    logic [0:0]           r_state;
    logic [c_idx_w-1:0]   r_grant_id;
    logic [c_idx_w-1:0]   r_last_grant;
    logic [c_cnt_w-1:0]   r_byte_cnt;
    logic [c_stall_w-1:0] r_stall_cnt;
    logic                 r_forced;

    logic                 w_xfer;
    logic                 w_xfer_en;
    logic                 w_own_valid;
    logic [7:0]           w_own_data;
    logic                 w_own_last;
    logic                 w_hs;
    logic [c_cnt_w-1:0]   w_byte_next;
    logic [c_stall_w-1:0] w_stall_next;
    logic                 w_cap_hit;
    logic                 w_stall_hit;
    logic                 w_release;
    logic                 w_forced_set;
    logic [c_idx_w-1:0]   w_pick;
    logic                 w_any;

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_picker (
        .i_req  (req_valid),
        .i_last (r_last_grant),
        .o_pick (w_pick),
        .o_any  (w_any)
    );

    // Owner select; the datapath is a pure mux of the granted requester.
    always_comb begin
        w_own_valid = 1'b0;
        w_own_data  = 8'h00;
        w_own_last  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant_id == c_idx_w'(i)) begin
                w_own_valid = req_valid[i];
                w_own_data  = req_data[8*i +: 8];
                w_own_last  = req_last[i];
            end
        end
    end

    // Reset also gates the datapath so a byte presented during reset is dropped.
    assign w_xfer    = (r_state == c_st_xfer);
    assign w_xfer_en = w_xfer && !osc_reset;

    assign tx_valid = w_xfer_en && w_own_valid;
    assign tx_data  = w_xfer_en ? w_own_data : 8'h00;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = w_xfer_en && (r_grant_id == c_idx_w'(i)) && tx_ready;
        end
    end

    assign w_hs         = tx_valid && tx_ready;
    assign w_byte_next  = r_byte_cnt + c_cnt_w'(1);
    assign w_cap_hit    = w_hs && (w_byte_next == c_cnt_max);
    assign w_stall_next = (r_stall_cnt == c_stall_max) ? r_stall_cnt
                                                       : r_stall_cnt + c_stall_w'(1);
    assign w_stall_hit  = w_xfer && !w_own_valid && (w_stall_next == c_stall_max);
    assign w_release    = w_xfer && ((w_hs && (w_own_last || w_cap_hit)) || w_stall_hit);
    assign w_forced_set = w_cap_hit || w_stall_hit;

    always_ff @(posedge osc_clk) begin
        if (osc_reset) begin
            r_state      <= c_st_idle;
            r_grant_id   <= '0;
            r_last_grant <= c_last_rst;
            r_byte_cnt   <= '0;
            r_stall_cnt  <= '0;
            r_forced     <= 1'b0;
        end else begin
            r_forced <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_any) begin
                        r_grant_id  <= w_pick;
                        r_byte_cnt  <= '0;
                        r_stall_cnt <= '0;
                        r_state     <= c_st_xfer;
                    end
                end
                c_st_xfer: begin
                    if (w_hs) begin
                        r_byte_cnt <= w_byte_next;
                    end
                    if (w_own_valid) begin
                        r_stall_cnt <= '0;
                    end else begin
                        r_stall_cnt <= w_stall_next;
                    end
                    if (w_release) begin
                        r_state      <= c_st_idle;
                        r_grant_id   <= '0;
                        r_last_grant <= r_grant_id;
                        r_forced     <= w_forced_set;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign grant_id       = r_grant_id;
    assign busy           = w_xfer;
    assign forced_release = r_forced;

endmodule : uart_tx_arbiter
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Brief    : Randomized scoreboard bench for uart_tx_arbiter.
// Revision : 1.0
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int N      = 3;
    localparam int MAXL   = 4;
    localparam int TMO    = 10;
    localparam int CYCLES = 4000;

    logic             osc_clk = 1'b0;
    logic             osc_reset;
    logic [N-1:0]     req_valid;
    logic [8*N-1:0]   req_data;
    logic [N-1:0]     req_last;
    logic [N-1:0]     req_ready;
    logic             tx_valid;
    logic [7:0]       tx_data;
    logic             tx_ready;
    logic [1:0]       grant_id;
    logic             busy;
    logic             forced_release;

    always #5 osc_clk = ~osc_clk;

    uart_tx_arbiter #(
        .NUM_REQ       (N),
        .MAX_PKT_LEN   (MAXL),
        .STALL_TIMEOUT (TMO)
    ) dut (
        .osc_clk        (osc_clk),
        .osc_reset      (osc_reset),
        .req_valid      (req_valid),
        .req_data       (req_data),
        .req_last       (req_last),
        .req_ready      (req_ready),
        .tx_valid       (tx_valid),
        .tx_data        (tx_data),
        .tx_ready       (tx_ready),
        .grant_id       (grant_id),
        .busy           (busy),
        .forced_release (forced_release)
    );

    typedef struct packed {
        logic         busy;
        logic [1:0]   gid;
        logic         fr;
        logic         tv;
        logic [7:0]   td;
        logic [N-1:0] rdy;
    } obs_t;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } byte_t;

    obs_t  obs_q[$];
    byte_t byte_q[$];

    int n_cmp = 0;
    int n_err = 0;
    bit mon_en = 1'b0;

    logic [7:0]   cur_data[N];
    logic         cur_last[N];
    int           sil[N];
    logic [N-1:0] acc;

    // Transaction-level view of the arbiter: owner index (-1 = idle) and counters.
    int m_own;
    int m_last;
    int m_cnt;
    int m_stall;
    bit m_fr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic new_byte(input int i);
        cur_data[i] = 8'($urandom);
        cur_last[i] = ($urandom_range(0, 2) == 0);
    endtask

    task automatic model_step();
        obs_t  e;
        byte_t b;
        int    o;
        bit    found;
        e      = '0;
        acc    = '0;
        e.fr   = m_fr;
        e.busy = (m_own >= 0);
        e.gid  = (m_own >= 0) ? 2'(m_own) : 2'd0;
        if (!osc_reset && m_own >= 0) begin
            o    = m_own;
            e.tv = req_valid[o];
            e.td = req_data[8*o +: 8];
            if (tx_ready) e.rdy[o] = 1'b1;
        end
        if (osc_reset) begin
            m_own   = -1;
            m_last  = N - 1;
            m_cnt   = 0;
            m_stall = 0;
            m_fr    = 1'b0;
        end else if (m_own < 0) begin
            m_fr  = 1'b0;
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                int i;
                i = (m_last + k) % N;
                if (!found && req_valid[i]) begin
                    found = 1'b1;
                    m_own = i;
                end
            end
            m_cnt   = 0;
            m_stall = 0;
        end else begin
            o    = m_own;
            m_fr = 1'b0;
            if (req_valid[o]) begin
                m_stall = 0;
                if (tx_ready) begin
                    b.id   = 2'(o);
                    b.data = req_data[8*o +: 8];
                    byte_q.push_back(b);
                    acc[o] = 1'b1;
                    m_cnt++;
                    if (req_last[o] || m_cnt == MAXL) begin
                        m_fr   = (m_cnt == MAXL);
                        m_last = o;
                        m_own  = -1;
                    end
                end
            end else begin
                m_stall++;
                if (m_stall >= TMO) begin
                    m_fr   = 1'b1;
                    m_last = o;
                    m_own  = -1;
                end
            end
        end
        obs_q.push_back(e);
    endtask

    always @(negedge osc_clk) begin
        obs_t  e;
        byte_t b;
        if (mon_en) begin
            if (obs_q.size() == 0) begin
                chk("obs_queue_depth", obs_q.size(), 1);
            end else begin
                e = obs_q.pop_front();
                chk("busy", busy, e.busy);
                chk("grant_id", grant_id, e.gid);
                chk("forced_release", forced_release, e.fr);
                chk("tx_valid", tx_valid, e.tv);
                chk("tx_data", tx_data, e.td);
                chk("req_ready", req_ready, e.rdy);
            end
            if (tx_valid && tx_ready) begin
                if (byte_q.size() == 0) begin
                    chk("byte_queue_depth", byte_q.size(), 1);
                end else begin
                    b = byte_q.pop_front();
                    chk("byte_owner", grant_id, b.id);
                    chk("byte_data", tx_data, b.data);
                end
            end
        end
    end

    initial begin
        logic v;
        osc_reset = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_ready  = 1'b0;
        acc       = '0;
        m_own     = -1;
        m_last    = N - 1;
        m_cnt     = 0;
        m_stall   = 0;
        m_fr      = 1'b0;
        for (int i = 0; i < N; i++) begin
            new_byte(i);
            sil[i] = 0;
        end
        repeat (2) @(posedge osc_clk);
        #1;
        for (int c = 0; c < CYCLES; c++) begin
            for (int i = 0; i < N; i++) begin
                if (acc[i]) new_byte(i);
            end
            osc_reset = (c < 2) || ($urandom_range(0, 299) == 0);
            tx_ready  = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (sil[i] > 0) begin
                    v = 1'b0;
                    sil[i]--;
                end else if ($urandom_range(0, 29) == 0) begin
                    sil[i] = $urandom_range(6, 14);
                    v = 1'b0;
                end else begin
                    v = ($urandom_range(0, 4) != 0);
                end
                req_valid[i]       = v;
                req_data[8*i +: 8] = cur_data[i];
                req_last[i]        = cur_last[i];
            end
            #1;
            mon_en = 1'b1;
            model_step();
            @(posedge osc_clk);
            #1;
        end
        mon_en = 1'b0;
        chk("obs_queue_left", obs_q.size(), 0);
        chk("byte_queue_left", byte_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_uart_tx_arbiter
`default_nettype wire
